// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH -> DECODE -> EXEC -> MEM -> WB, with
// op-class decode for Func_Sel, datapath strobes, retired count and error pulses.
module multicycle_ctrl #(
  parameter int FUNC_SIZE   = 11,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr,
  input  logic                 instr_valid,
  input  logic                 alu_zero,
  input  logic                 mem_ready,
  output logic [1:0]           op_sel,
  output logic [FUNC_SIZE-1:0] func,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 branch_we,
  output logic                 mem_re,
  output logic                 mem_we,
  output logic                 reg_we,
  output logic                 reg_dst,
  output logic                 illegal_op,
  output logic                 mem_err,
  output logic [CNT_W-1:0]     retired
);

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  localparam logic [1:0] OP_CALCU = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_SAVE  = 2'b10;
  localparam logic [1:0] OP_BEQ   = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
  } state_t;

  state_t                state_q, state_d;
  logic [5:0]            opc_q, opc_d;
  logic [FUNC_SIZE-1:0]  fn_q, fn_d;
  logic [1:0]            op_sel_q, op_sel_d;
  logic [FUNC_SIZE-1:0]  func_q, func_d;
  logic [CNT_W-1:0]      retired_q, retired_d;
  logic [TO_W-1:0]       cnt_q, cnt_d;

  // Only the opcode and func bits of the instruction matter to control.
  logic unused_instr;
  assign unused_instr = ^instr[25:FUNC_SIZE];

  always_comb begin
    state_d    = state_q;
    opc_d      = opc_q;
    fn_d       = fn_q;
    op_sel_d   = op_sel_q;
    func_d     = func_q;
    retired_d  = retired_q;
    cnt_d      = cnt_q;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    branch_we  = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    illegal_op = 1'b0;
    mem_err    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (instr_valid) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          opc_d   = instr[31:26];
          fn_d    = instr[FUNC_SIZE-1:0];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
        case (opc_q)
          6'b000000: begin op_sel_d = OP_CALCU; func_d = fn_q; end
          6'b100011: begin op_sel_d = OP_LOAD;  func_d = '0;   end
          6'b101011: begin op_sel_d = OP_SAVE;  func_d = '0;   end
          6'b000100: begin op_sel_d = OP_BEQ;   func_d = '0;   end
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        case (op_sel_q)
          OP_CALCU: state_d = S_WB;
          OP_LOAD, OP_SAVE: begin
            cnt_d   = '0;
            state_d = S_MEM;
          end
          default: begin
            branch_we = alu_zero;
            retired_d = retired_q + CNT_W'(1);
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        mem_re = (op_sel_q == OP_LOAD);
        mem_we = (op_sel_q == OP_SAVE);
        cnt_d  = cnt_q + TO_W'(1);
        // A ready arriving on the last allowed cycle still counts as success.
        if (mem_ready) begin
          if (op_sel_q == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = S_FETCH;
          end
        end else if (cnt_q == TO_LAST) begin
          mem_err = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        reg_we    = 1'b1;
        reg_dst   = (op_sel_q == OP_CALCU);
        retired_d = retired_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_sel_q  <= OP_CALCU;
      func_q    <= '0;
      retired_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_sel_q  <= op_sel_d;
      func_q    <= func_d;
      retired_q <= retired_d;
      cnt_q     <= cnt_d;
    end
  end

  // Instruction fields are only consumed after a FETCH capture, so no reset.
  always_ff @(posedge clk) begin
    opc_q <= opc_d;
    fn_q  <= fn_d;
  end

  assign op_sel  = op_sel_q;
  assign func    = func_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: a per-instruction sequence model
// predicts every cycle's strobes plus op_sel/func/retired.
module tb_multicycle_ctrl;

  localparam int TO = 16;

  localparam logic [8:0] E_IR = 9'h180;
  localparam logic [8:0] E_BR = 9'h040;
  localparam logic [8:0] E_RE = 9'h020;
  localparam logic [8:0] E_WE = 9'h010;
  localparam logic [8:0] E_RW = 9'h008;
  localparam logic [8:0] E_RD = 9'h004;
  localparam logic [8:0] E_IL = 9'h002;
  localparam logic [8:0] E_ME = 9'h001;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid, alu_zero, mem_ready;
  logic [1:0]  op_sel;
  logic [10:0] func;
  logic        ir_we, pc_we, branch_we, mem_re, mem_we, reg_we, reg_dst;
  logic        illegal_op, mem_err;
  logic [31:0] retired;

  int total = 0;
  int bad   = 0;

  logic [1:0]  m_op;
  logic [10:0] m_func;
  logic [31:0] m_ret;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .op_sel(op_sel), .func(func),
    .ir_we(ir_we), .pc_we(pc_we), .branch_we(branch_we), .mem_re(mem_re),
    .mem_we(mem_we), .reg_we(reg_we), .reg_dst(reg_dst),
    .illegal_op(illegal_op), .mem_err(mem_err), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] strobes();
    return {ir_we, pc_we, branch_we, mem_re, mem_we, reg_we, reg_dst, illegal_op, mem_err};
  endfunction

  // Called at a negedge: drive inputs, check this cycle's outputs, advance one cycle.
  task automatic step(input logic [31:0] ins, input logic iv, input logic rdy,
                      input logic az, input logic [8:0] es, input string tag);
    instr = ins; instr_valid = iv; mem_ready = rdy; alu_zero = az;
    #1;
    check({tag, "/strobes"}, 64'(strobes()), 64'(es));
    check({tag, "/op_sel"}, 64'(op_sel), 64'(m_op));
    check({tag, "/func"}, 64'(func), 64'(m_func));
    check({tag, "/retired"}, 64'(retired), 64'(m_ret));
    @(negedge clk);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // ready_at: MEM cycle (1-based) where mem_ready rises; outside 1..TO means never.
  // abort_at: MEM cycle in which rst is asserted instead (0 = none).
  task automatic run_instr(input logic [31:0] ins, input logic az, input int ready_at,
                           input int abort_at, input string tag);
    logic [5:0] opc;
    logic is_r, is_l, is_s, is_b;
    logic [8:0] es;
    logic rdy;
    opc  = ins[31:26];
    is_r = (opc == 6'h00);
    is_l = (opc == 6'h23);
    is_s = (opc == 6'h2B);
    is_b = (opc == 6'h04);
    for (int i = 0; i < int'($urandom_range(0, 2)); i++)
      step($urandom, 1'b0, rb(), rb(), 9'h0, {tag, "/idle"});
    step(ins, 1'b1, rb(), rb(), E_IR, {tag, "/fetch"});
    step($urandom, rb(), rb(), rb(), (is_r | is_l | is_s | is_b) ? 9'h0 : E_IL, {tag, "/decode"});
    if (!(is_r | is_l | is_s | is_b)) return;
    m_op   = is_r ? 2'b00 : is_l ? 2'b01 : is_s ? 2'b10 : 2'b11;
    m_func = is_r ? ins[10:0] : 11'h0;
    step($urandom, rb(), rb(), az, (is_b && az) ? E_BR : 9'h0, {tag, "/exec"});
    if (is_b) begin
      m_ret++;
      return;
    end
    if (is_l || is_s) begin
      for (int k = 1; k <= TO; k++) begin
        if (abort_at == k) begin
          rst = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          m_op = 2'b00; m_func = 11'h0; m_ret = 32'h0;
          step($urandom, 1'b0, rb(), rb(), 9'h0, {tag, "/post_rst"});
          return;
        end
        rdy = (k == ready_at);
        es  = is_l ? E_RE : E_WE;
        if (!rdy && k == TO) es |= E_ME;
        step($urandom, rb(), rdy, rb(), es, {tag, "/mem"});
        if (rdy) begin
          if (is_s) begin
            m_ret++;
            return;
          end
          break;
        end
        if (k == TO) return;
      end
    end
    step($urandom, rb(), rb(), rb(), E_RW | (is_r ? E_RD : 9'h0), {tag, "/wb"});
    m_ret++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic [5:0]  op;
    int cls;
    rst = 1'b1; instr = 32'h0; instr_valid = 1'b0; alu_zero = 1'b0; mem_ready = 1'b0;
    m_op = 2'b00; m_func = 11'h0; m_ret = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("reset/strobes", 64'(strobes()), 64'h0);
    check("reset/op_sel", 64'(op_sel), 64'h0);
    check("reset/func", 64'(func), 64'h0);
    check("reset/retired", 64'(retired), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    run_instr(32'h00221820, 1'b0, 0, 0, "add");
    run_instr(32'h8C220004, 1'b0, 3, 0, "lw");
    run_instr(32'h10220003, 1'b1, 0, 0, "beq_taken");
    run_instr(32'h10220003, 1'b0, 0, 0, "beq_not");
    run_instr(32'hFC000000, 1'b0, 0, 0, "illegal");
    run_instr(32'hAC220000, 1'b0, 0, 0, "sw_timeout");
    run_instr(32'hAC220000, 1'b0, 16, 0, "sw_ready16");
    run_instr(32'h8C220004, 1'b0, 16, 0, "lw_ready16");
    run_instr(32'h00221820, 1'b0, 0, 0, "add2");
    run_instr(32'h8C220004, 1'b0, 0, 2, "lw_abort");
    run_instr(32'h00221820, 1'b0, 0, 0, "add_after_rst");

    for (int n = 0; n < 60; n++) begin
      r   = $urandom;
      cls = int'($urandom_range(0, 4));
      case (cls)
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h04;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04)
            op = 6'($urandom_range(0, 63));
        end
      endcase
      run_instr({op, r[25:0]}, rb(), int'($urandom_range(0, 18)), 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
